// File: rtl/knap_search.sv
// Knapsack search engine: walks every item selection in Gray-code order, checks the
// value/weight/volume limits incrementally, streams valid selections and keeps best/count.
//
// state | meaning
// IDLE  | waiting for start; coefficient table writable
// SCAN  | one candidate per cycle, holds while a valid candidate has no hit slot
// DRAIN | waiting for the last hit to be taken, then pulses done
module knap_search #(
  parameter int N_ITEMS = 23,
  parameter int COEF_W  = 5,
  parameter int SUM_W   = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [$clog2(N_ITEMS)-1:0]   cfg_addr,
  input  logic [COEF_W-1:0]            cfg_value,
  input  logic [COEF_W-1:0]            cfg_weight,
  input  logic [COEF_W-1:0]            cfg_volume,
  input  logic [SUM_W-1:0]             min_value,
  input  logic [SUM_W-1:0]             max_weight,
  input  logic [SUM_W-1:0]             max_volume,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         hit_valid,
  input  logic                         hit_ready,
  output logic [N_ITEMS-1:0]           hit_sel,
  output logic                         best_valid,
  output logic [N_ITEMS-1:0]           best_sel,
  output logic [SUM_W-1:0]             best_value,
  output logic [N_ITEMS:0]             valid_count
);

  localparam int IDX_W = $clog2(N_ITEMS);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [COEF_W-1:0]  tbl_value  [N_ITEMS];
  logic [COEF_W-1:0]  tbl_weight [N_ITEMS];
  logic [COEF_W-1:0]  tbl_volume [N_ITEMS];

  logic [SUM_W-1:0]   lim_min, lim_weight, lim_volume;
  logic [SUM_W-1:0]   tot_value, tot_weight, tot_volume;
  logic [N_ITEMS-1:0] sel, k, k_nxt, flip;
  logic [IDX_W-1:0]   flip_idx;
  logic               flip_up;
  logic [COEF_W-1:0]  coef_value, coef_weight, coef_volume;

  logic cand_ok, slot_free, last, launch, eval, finish;

  assign cand_ok   = (tot_value >= lim_min) && (tot_weight <= lim_weight) &&
                     (tot_volume <= lim_volume);
  assign slot_free = !hit_valid || hit_ready;
  assign last      = &k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    eval      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        // A valid candidate with nowhere to go freezes the whole walk.
        if (!(cand_ok && !slot_free)) begin
          eval = 1'b1;
          if (last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (slot_free) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The lowest set bit of k+1 is the single Gray bit that flips next.
  always_comb begin
    k_nxt    = k + 1'b1;
    flip     = k_nxt & ~k;
    flip_idx = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (flip[i]) flip_idx = IDX_W'(i);
    end
    flip_up     = ~sel[flip_idx];
    coef_value  = tbl_value[flip_idx];
    coef_weight = tbl_weight[flip_idx];
    coef_volume = tbl_volume[flip_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        tbl_value[i]  <= '0;
        tbl_weight[i] <= '0;
        tbl_volume[i] <= '0;
      end
    end else if (cfg_we && !busy && (int'(cfg_addr) < N_ITEMS)) begin
      tbl_value[cfg_addr]  <= cfg_value;
      tbl_weight[cfg_addr] <= cfg_weight;
      tbl_volume[cfg_addr] <= cfg_volume;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      hit_valid   <= 1'b0;
      hit_sel     <= '0;
      best_valid  <= 1'b0;
      best_sel    <= '0;
      best_value  <= '0;
      valid_count <= '0;
      lim_min     <= '0;
      lim_weight  <= '0;
      lim_volume  <= '0;
      tot_value   <= '0;
      tot_weight  <= '0;
      tot_volume  <= '0;
      sel         <= '0;
      k           <= '0;
    end else begin
      done <= finish;
      if (launch)      busy <= 1'b1;
      else if (finish) busy <= 1'b0;

      if (hit_valid && hit_ready) hit_valid <= 1'b0;

      if (launch) begin
        lim_min     <= min_value;
        lim_weight  <= max_weight;
        lim_volume  <= max_volume;
        sel         <= '0;
        k           <= '0;
        tot_value   <= '0;
        tot_weight  <= '0;
        tot_volume  <= '0;
        best_valid  <= 1'b0;
        best_sel    <= '0;
        best_value  <= '0;
        valid_count <= '0;
      end

      if (eval && cand_ok) begin
        hit_valid   <= 1'b1;
        hit_sel     <= sel;
        valid_count <= valid_count + 1'b1;
        if (!best_valid || tot_value > best_value) begin
          best_valid <= 1'b1;
          best_sel   <= sel;
          best_value <= tot_value;
        end
      end

      if (eval && !last) begin
        k   <= k_nxt;
        sel <= sel ^ flip;
        if (flip_up) begin
          tot_value  <= tot_value  + SUM_W'(coef_value);
          tot_weight <= tot_weight + SUM_W'(coef_weight);
          tot_volume <= tot_volume + SUM_W'(coef_volume);
        end else begin
          tot_value  <= tot_value  - SUM_W'(coef_value);
          tot_weight <= tot_weight - SUM_W'(coef_weight);
          tot_volume <= tot_volume - SUM_W'(coef_volume);
        end
      end
    end
  end

endmodule

// File: tb/tb_knap_search.sv
// Scoreboard bench for knap_search with 4 items: a direct enumeration model queues the
// expected hits at start, each accepted hit is popped and compared.
module tb_knap_search;
  localparam int N  = 4;
  localparam int CW = 5;
  localparam int SW = 10;
  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [CW-1:0] cfg_value, cfg_weight, cfg_volume;
  logic [SW-1:0] min_value, max_weight, max_volume;
  logic          start;
  logic          busy, done, hit_valid, hit_ready;
  logic [N-1:0]  hit_sel, best_sel;
  logic          best_valid;
  logic [SW-1:0] best_value;
  logic [N:0]    valid_count;

  knap_search #(.N_ITEMS(N), .COEF_W(CW), .SUM_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_value(cfg_value), .cfg_weight(cfg_weight), .cfg_volume(cfg_volume),
    .min_value(min_value), .max_weight(max_weight), .max_volume(max_volume),
    .start(start), .busy(busy), .done(done), .hit_valid(hit_valid),
    .hit_ready(hit_ready), .hit_sel(hit_sel), .best_valid(best_valid),
    .best_sel(best_sel), .best_value(best_value), .valid_count(valid_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int tv[N], tw[N], tvol[N];
  logic [N-1:0] exp_q[$];
  int exp_count, exp_best_valid, exp_best_sel, exp_best_value;
  int cyc, done_cnt, done_cycle;

  task automatic build_model(input int mn, input int mw, input int mvol);
    exp_q.delete();
    exp_count = 0; exp_best_valid = 0; exp_best_sel = 0; exp_best_value = 0;
    for (int k = 0; k < (1 << N); k++) begin
      int g, sv, sw, svol;
      g = k ^ (k >> 1);
      sv = 0; sw = 0; svol = 0;
      for (int i = 0; i < N; i++) begin
        if (((g >> i) & 1) == 1) begin
          sv += tv[i]; sw += tw[i]; svol += tvol[i];
        end
      end
      if (sv >= mn && sw <= mw && svol <= mvol) begin
        exp_q.push_back(N'(g));
        exp_count++;
        if (exp_best_valid == 0 || sv > exp_best_value) begin
          exp_best_valid = 1; exp_best_sel = g; exp_best_value = sv;
        end
      end
    end
  endtask

  task automatic tick();
    logic hv, hr;
    logic [N-1:0] hs;
    hv = hit_valid; hr = hit_ready; hs = hit_sel;
    @(posedge clk); #1;
    cyc++;
    if (hv && hr) begin
      if (exp_q.size() == 0) check("hit_extra", 32'(exp_q.size()), 1);
      else                   check("hit_sel", hs, exp_q.pop_front());
    end
    if (hv && !hr) begin
      check("hold_valid", hit_valid, 1);
      check("hold_sel", hit_sel, hs);
    end
    if (done) begin
      done_cnt++;
      done_cycle = cyc;
    end
  endtask

  task automatic cfg_write(input int a, input int v, input int w, input int vol);
    cfg_we = 1'b1; cfg_addr = AW'(a);
    cfg_value = CW'(v); cfg_weight = CW'(w); cfg_volume = CW'(vol);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run(input int mn, input int mw, input int mvol, input int stall_len,
                     input bit disturb, input int exp_done);
    bit stalled;
    int left;
    build_model(mn, mw, mvol);
    min_value = SW'(mn); max_weight = SW'(mw); max_volume = SW'(mvol);
    hit_ready = 1'b1;
    done_cnt = 0; done_cycle = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    check("busy_after_start", busy, 1);
    stalled = 0; left = 0;
    while (done_cnt == 0 && cyc < 200) begin
      if (stall_len > 0 && !stalled && hit_valid) begin
        hit_ready = 1'b0; left = stall_len; stalled = 1;
      end
      if (disturb && cyc == 5) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = '0;
        cfg_value = 5'd31; cfg_weight = 5'd0; cfg_volume = 5'd0;
      end
      tick();
      start = 1'b0; cfg_we = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) hit_ready = 1'b1;
      end
    end
    check("done_cycle", done_cycle, exp_done);
    check("busy_at_done", busy, 0);
    tick();
    check("done_pulse", done, 0);
    check("done_count", done_cnt, 1);
    check("hits_left", exp_q.size(), 0);
    check("valid_count", valid_count, exp_count);
    check("best_valid", best_valid, exp_best_valid);
    check("best_sel", best_sel, exp_best_sel);
    check("best_value", best_value, exp_best_value);
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_value = '0; cfg_weight = '0; cfg_volume = '0;
    min_value = '0; max_weight = '0; max_volume = '0;
    start = 1'b0; hit_ready = 1'b1; cyc = 0; done_cnt = 0; done_cycle = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hit_valid", hit_valid, 0);
    check("rst_hit_sel", hit_sel, 0);
    check("rst_best_valid", best_valid, 0);
    check("rst_best_sel", best_sel, 0);
    check("rst_best_value", best_value, 0);
    check("rst_valid_count", valid_count, 0);
    rst_n = 1'b1;
    tick();

    tv   = '{4, 8, 0, 20};
    tw   = '{28, 8, 27, 18};
    tvol = '{27, 27, 4, 4};
    for (int i = 0; i < N; i++) cfg_write(i, tv[i], tw[i], tvol[i]);

    run(20, 30, 40, 0, 0, 17);
    check("base_count", valid_count, 2);
    check("base_best_sel", best_sel, 4'b1010);
    check("base_best_value", best_value, 28);

    // First hit appears after candidate 12; candidates 13 and 14 are invalid and run on,
    // so 8 of the 10 not-ready cycles stall the last candidate.
    run(20, 30, 40, 10, 0, 17 + 8);
    check("stall_best_sel", best_sel, 4'b1010);

    run(0, 1023, 1023, 0, 0, 17);
    check("all_count", valid_count, 16);

    run(100, 1023, 1023, 0, 0, 17);
    check("none_count", valid_count, 0);

    run(20, 30, 40, 0, 1, 17);
    run(20, 30, 40, 0, 0, 17);

    build_model(0, 1023, 1023);
    min_value = '0; max_weight = 10'd1023; max_volume = 10'd1023;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hit_valid", hit_valid, 0);
    check("mid_rst_hit_sel", hit_sel, 0);
    check("mid_rst_best_valid", best_valid, 0);
    check("mid_rst_best_value", best_value, 0);
    check("mid_rst_count", valid_count, 0);
    exp_q.delete();
    repeat (2) begin
      @(posedge clk); #1;
      check("mid_rst_done", done, 0);
    end
    rst_n = 1'b1;
    tick();
    check("post_rst_done", done, 0);

    tv = '{0, 0, 0, 0}; tw = '{0, 0, 0, 0}; tvol = '{0, 0, 0, 0};
    run(0, 1023, 1023, 0, 0, 17);
    check("cleared_best_sel", best_sel, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "timeout");
  end

endmodule
